ram_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the 16x8 scratch RAM (ram: clk, Address, in, out, WE, CS).

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arbiter_rr_pick2.sv | 21 ++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port scratch-RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned AW_DEF     = 4;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin or fixed port-0 priority.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  input  logic       prio_mode_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = 1'b0;
    case (req_i)
      2'b10:   gnt_id_o = 1'b1;
      // Tie: fixed mode favours port 0, round-robin favours the port not served last.
      2'b11:   gnt_id_o = prio_mode_i ? 1'b0 : ~rr_last_i;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer sharing one 16x8 RAM port between a CPU port and a loader port.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_we,
  output logic          ram_cs
);

  arb_state_e    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          rr_last_q, rr_last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cs_q, cs_d;
  logic          wen_q, wen_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          pick_id, pick_valid;

  rr_pick2 u_pick (
    .req_i       ({req1, req0}),
    .rr_last_i   (rr_last_q),
    .prio_mode_i (PRIO_MODE == PRIO_FIXED),
    .gnt_id_o    (pick_id),
    .gnt_valid_o (pick_valid)
  );

  // The ram_* registers double as the latched request copy, so CS/WE are glitch-free flops.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    cs_d      = 1'b0;
    wen_d     = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          gnt_d   = pick_id;
          addr_d  = pick_id ? addr1  : addr0;
          din_d   = pick_id ? wdata1 : wdata0;
          wen_d   = pick_id ? we1    : we0;
          cs_d    = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        if (!wen_q) rdata_d = ram_dout;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      ST_ACK: begin
        state_d   = ST_IDLE;
        rr_last_d = gnt_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      wen_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      wen_q     <= wen_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_we   = wen_q;
  assign ram_cs   = cs_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench: round-robin and fixed-priority arbiters driven in parallel, each with its own RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;

  logic       ack0_r, ack1_r, busy_r, rwe_r, rcs_r;
  logic [7:0] rdata_r, rdin_r;
  logic [3:0] raddr_r;
  logic       ack0_f, ack1_f, busy_f, rwe_f, rcs_f;
  logic [7:0] rdata_f, rdin_f;
  logic [3:0] raddr_f;
  wire  [7:0] dout_r, dout_f;

  logic [7:0] ram_r [16];
  logic [7:0] ram_f [16];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.AW(4), .DW(8), .PRIO_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_r),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_r),
    .rdata(rdata_r), .busy(busy_r), .ram_addr(raddr_r), .ram_din(rdin_r),
    .ram_dout(dout_r), .ram_we(rwe_r), .ram_cs(rcs_r)
  );

  ram_arbiter #(.AW(4), .DW(8), .PRIO_MODE(1)) u_fx (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_f),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_f),
    .rdata(rdata_f), .busy(busy_f), .ram_addr(raddr_f), .ram_din(rdin_f),
    .ram_dout(dout_f), .ram_we(rwe_f), .ram_cs(rcs_f)
  );

  // RAM stand-ins: synchronous write, asynchronous read, output floats when deselected.
  always @(posedge clk) if (rcs_r && rwe_r) ram_r[raddr_r] <= rdin_r;
  always @(posedge clk) if (rcs_f && rwe_f) ram_f[raddr_f] <= rdin_f;
  assign dout_r = rcs_r ? ram_r[raddr_r] : 8'hzz;
  assign dout_f = rcs_f ? ram_f[raddr_f] : 8'hzz;

  // Outputs gathered per instance: index 0 = round-robin, 1 = fixed priority.
  logic       o_ack0 [2], o_ack1 [2], o_busy [2], o_cs [2], o_we [2];
  logic [7:0] o_rdata [2], o_din [2];
  logic [3:0] o_addr [2];
  assign o_ack0[0] = ack0_r;  assign o_ack0[1] = ack0_f;
  assign o_ack1[0] = ack1_r;  assign o_ack1[1] = ack1_f;
  assign o_busy[0] = busy_r;  assign o_busy[1] = busy_f;
  assign o_cs[0]   = rcs_r;   assign o_cs[1]   = rcs_f;
  assign o_we[0]   = rwe_r;   assign o_we[1]   = rwe_f;
  assign o_rdata[0] = rdata_r; assign o_rdata[1] = rdata_f;
  assign o_din[0]  = rdin_r;  assign o_din[1]  = rdin_f;
  assign o_addr[0] = raddr_r; assign o_addr[1] = raddr_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each access occupies a 3-cycle slot counted down by m_left
  // (2 = RAM cycle, 1 = ack cycle, 0 = free to arbitrate).
  int         m_left  [2];
  logic       m_gnt   [2];
  logic       m_we    [2];
  logic       m_last  [2];
  logic [3:0] m_addr  [2];
  logic [7:0] m_wd    [2];
  logic [7:0] m_rdata [2];
  logic [7:0] m_mem   [2][16];

  initial begin
    for (int p = 0; p < 2; p++) begin
      m_left[p] = 0; m_gnt[p] = 1'b0; m_we[p] = 1'b0; m_last[p] = 1'b1;
      m_addr[p] = '0; m_wd[p] = '0; m_rdata[p] = '0;
      for (int a = 0; a < 16; a++) m_mem[p][a] = '0;
    end
    for (int a = 0; a < 16; a++) begin
      ram_r[a] = '0;
      ram_f[a] = '0;
    end
  end

  always @(posedge clk) begin
    logic w;
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        if (m_left[p] == 2 && m_we[p]) m_mem[p][m_addr[p]] = m_wd[p];
        m_left[p]  = 0;
        m_rdata[p] = '0;
        m_last[p]  = 1'b1;
      end else if (m_left[p] == 2) begin
        if (m_we[p]) m_mem[p][m_addr[p]] = m_wd[p];
        else         m_rdata[p] = m_mem[p][m_addr[p]];
        m_left[p] = 1;
      end else if (m_left[p] == 1) begin
        m_last[p] = m_gnt[p];
        m_left[p] = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) w = (p == 1) ? 1'b0 : ~m_last[p];
        else              w = req1;
        m_gnt[p]  = w;
        m_we[p]   = w ? we1 : we0;
        m_addr[p] = w ? addr1 : addr0;
        m_wd[p]   = w ? wdata1 : wdata0;
        m_left[p] = 2;
      end
    end
  end

  always @(negedge clk) begin
    string pn;
    if (cyc >= 1) begin
      for (int p = 0; p < 2; p++) begin
        pn = (p == 0) ? "rr" : "fx";
        chk({pn, ".ack0"},  o_ack0[p],  (m_left[p] == 1 && !m_gnt[p]));
        chk({pn, ".ack1"},  o_ack1[p],  (m_left[p] == 1 &&  m_gnt[p]));
        chk({pn, ".busy"},  o_busy[p],  (m_left[p] != 0));
        chk({pn, ".cs"},    o_cs[p],    (m_left[p] == 2));
        chk({pn, ".we"},    o_we[p],    (m_left[p] == 2 && m_we[p]));
        chk({pn, ".rdata"}, o_rdata[p], m_rdata[p]);
        if (m_left[p] == 2) begin
          chk({pn, ".ram_addr"}, o_addr[p], m_addr[p]);
          chk({pn, ".ram_din"},  o_din[p],  m_wd[p]);
        end
      end
    end
  end

  // One isolated access from a single port; both instances must behave identically.
  task automatic single(input int port, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic chk_rd, input logic [7:0] exp_rd);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    @(posedge clk); @(negedge clk);
    chk("single.cs_rr", rcs_r, 1'b1);
    chk("single.cs_fx", rcs_f, 1'b1);
    chk("single.we_rr", rwe_r, we);
    @(posedge clk); @(negedge clk);
    chk("single.ack_rr", (port == 0) ? ack0_r : ack1_r, 1'b1);
    chk("single.ack_fx", (port == 0) ? ack0_f : ack1_f, 1'b1);
    if (chk_rd) begin
      chk("single.rdata_rr", rdata_r, exp_rd);
      chk("single.rdata_fx", rdata_f, exp_rd);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    logic [3:0] seq_r, seq_f;
    int         n_r, n_f;
    int         ack_cyc [$];

    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.ack0",  {ack0_r, ack0_f}, 2'b00);
    chk("reset.ack1",  {ack1_r, ack1_f}, 2'b00);
    chk("reset.busy",  {busy_r, busy_f}, 2'b00);
    chk("reset.cswe",  {rcs_r, rwe_r, rcs_f, rwe_f}, 4'b0000);
    chk("reset.rdata", {rdata_r, rdata_f}, 16'h0000);
    chk("reset.addr",  {raddr_r, raddr_f}, 8'h00);
    chk("reset.din",   {rdin_r, rdin_f}, 16'h0000);

    // Write then read back through port 0.
    single(0, 1'b1, 4'd3, 8'h0A, 1'b0, 8'h00);
    single(0, 1'b0, 4'd3, 8'h00, 1'b1, 8'h0A);

    // A write must leave the last read data untouched.
    single(1, 1'b1, 4'd7, 8'h77, 1'b0, 8'h00);
    @(negedge clk);
    chk("hold.rdata_rr", rdata_r, 8'h0A);
    chk("hold.rdata_fx", rdata_f, 8'h0A);

    // Address extremes.
    single(1, 1'b1, 4'd15, 8'hF0, 1'b0, 8'h00);
    single(0, 1'b1, 4'd0,  8'h0C, 1'b0, 8'h00);
    single(0, 1'b0, 4'd15, 8'h00, 1'b1, 8'hF0);
    single(1, 1'b0, 4'd0,  8'h00, 1'b1, 8'h0C);

    // Contention: both held for three slots, then port 0 drops and port 1 gets one more.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h22;
    seq_r = '0; seq_f = '0; n_r = 0; n_f = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 8)  req0 = 1'b0;
      if (c == 11) req1 = 1'b0;
      @(negedge clk);
      if (ack0_r || ack1_r) begin seq_r = {seq_r[2:0], ack1_r}; n_r++; end
      if (ack0_f || ack1_f) begin seq_f = {seq_f[2:0], ack1_f}; n_f++; end
    end
    chk("rr.ack_count", n_r, 4);
    chk("rr.ack_order", seq_r, 4'b0101);
    chk("fx.ack_count", n_f, 4);
    chk("fx.ack_order", seq_f, 4'b0001);
    single(0, 1'b0, 4'd1, 8'h00, 1'b1, 8'h11);
    single(1, 1'b0, 4'd2, 8'h00, 1'b1, 8'h22);

    // Held request: two back-to-back reads, acks exactly 3 cycles apart.
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack1_r) ack_cyc.push_back(cyc);
    end
    req1 = 1'b0;
    chk("held.ack_count", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("held.ack_spacing", ack_cyc[1] - ack_cyc[0], 3);
    chk("held.rdata", rdata_r, 8'h22);

    // Reset landing on the RAM cycle of a write: no ack, write still lands.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h55;
    @(posedge clk); #1;
    reset = 1'b1;
    req0  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst.ack",   {ack0_r, ack1_r, ack0_f, ack1_f}, 4'b0000);
    chk("rst.busy",  {busy_r, busy_f}, 2'b00);
    chk("rst.rdata", {rdata_r, rdata_f}, 16'h0000);
    single(0, 1'b0, 4'd5, 8'h00, 1'b1, 8'h55);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
